// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: drains it into a valid/ready stream via a skid buffer.
// Optional: define FIFO_RD_STATS_EN to add the saturating Word_Count output.
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 8,
    parameter int BUF_DEPTH  = 2
`ifdef FIFO_RD_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Fifo_Empty,
    input  logic [FIFO_WIDTH-1:0] Fifo_Data,
    output logic                  Fifo_Rd_Req,
    output logic [FIFO_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  Word_Count
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // Two extra bits keep count + inflight - pop clear of wrap-around.
    localparam int CW = $clog2(BUF_DEPTH) + 2;
    localparam logic [CW-1:0]    DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  inflight;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign Out_Valid = (count != '0);
    assign Out_Data  = mem[rd_ptr];
    assign pop       = Out_Valid && Out_Ready;
    assign count_nxt = count + CW'(inflight) - CW'(pop);

    // Credit check: only request when the word would still have a free slot on arrival.
    assign Fifo_Rd_Req = !RST && !Fifo_Empty && (count_nxt < DEPTH_C);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count    <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            // NOTE: the buffer is reset so Out_Data reads 0 after reset; this keeps it in flops, not RAM.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every register here sees pre-edge values of the others.
            inflight <= Fifo_Rd_Req;
            count    <= count_nxt;
            if (inflight) begin
                mem[wr_ptr] <= Fifo_Data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            Word_Count <= '0;
        end else if (pop && (Word_Count != '1)) begin
            Word_Count <= Word_Count + 1'b1;
        end
    end
`endif

    overflow_chk: assert property (@(posedge CLK) disable iff (RST) count <= DEPTH_C);

endmodule
